rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the register file's single write port (PW/RW/LE) between two writeback requesters: port 0 for ALU results and port 1 for memory-load results. Each requester has a small FIFO with a valid/ready handshake. A round-robin arbiter drains the FIFOs and issues one registered write per cycle to the register file. A per-register busy vector lets decode logic stall on registers that have writes in flight. Writes to register 0 (%g0) are accepted and then discarded.

## Interface
- DEPTH, 2, entries per requester FIFO; must be a power of 2 and at least 2
- DW, 32, data width; must match the register file's PW
- Clk  input  1  rising-edge clock, shared with the register file
- Rst  input  1  asynchronous, active-high reset
- V0, V1  input  1 each  request valid, ports 0 and 1
- R0, R1  output  1 each  ready; a transfer occurs on a rising edge when V and R are both 1
- RW0, RW1  input  5 each  destination register number
- D0, D1  input  DW each  write data
- LE  output  1  load enable to the register file, registered
- RW  output  5  write register number to the register file, registered
- PW  output  DW  write data to the register file, registered
- Busy  output  32  bit n = 1 while any write to register n is queued or on the output stage
- Idle  output  1  1 when both FIFOs are empty and LE = 0

## Operation
- **Reset state (async, immediate):** both FIFOs empty, LE=0, RW=0, PW=0, round-robin pointer Last=1 (port 0 wins first), Busy=0, Idle=1, R0=R1=1.
- **Ready.** Rn = 1 iff FIFO n count < DEPTH, taken from the count register only. There is no same-cycle pop-to-push bypass, so a full FIFO deasserts Rn even if it is popped in that cycle.
- **Push.** On Vn & Rn, the pair {RWn, Dn} is written at the tail and count increments.
- **Arbitration** (combinational on FIFO heads, evaluated each cycle):
  - Neither FIFO non-empty: no grant.
  - Exactly one FIFO non-empty: that FIFO is granted.
  - Both non-empty: the port ≠ Last is granted.
  - On a grant, the granted FIFO pops at the edge and Last becomes the granted port.
- **Output stage** (updated every edge):
  - Grant with head RW ≠ 0: LE←1, RW←head.RW, PW←head.D.
  - Grant with head RW = 0: LE←0; RW/PW hold their values; the entry is silently dropped.
  - No grant: LE←0; RW/PW hold their values.
- **Simultaneous push and pop on the same FIFO:** count is unchanged; order is preserved.
- **Pointer wrap:** read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- **Busy.** Busy = OR over all valid FIFO entries of onehot(entry.RW), OR onehot(RW) when LE=1. Bit 0 is forced to 0.
- **Ordering.** Writes from the same port reach the register file in push order. The relative order across ports is by grant only; upstream guarantees that the two ports never target the same register concurrently.
- **Reset mid-operation:** all queued entries are lost and LE drops immediately; no partial write is issued.

## Timing
- Push at edge N → earliest LE=1 after edge N+1 → register file captures at edge N+2. Push-to-write latency is 2 cycles when uncontended.
- **Throughput:** 1 write per cycle aggregate. Under continuous contention each port gets every other cycle.
- LE stays high for exactly one cycle per write unless back-to-back grants occur.
- Busy bit n rises in the cycle after the push edge and falls in the cycle after the register-file capture edge, i.e. after the edge where LE=0 or RW≠n is loaded.
- R0, R1, Busy and Idle are registered-state derived and have no combinational path from Vn.

## Test plan
1. **Reset:** Rst=1 mid-simulation with entries queued → LE=0, RW=0, PW=0, Busy=0, Idle=1, R0=R1=1 immediately, before the next edge.
2. **Single write:** V0=1, RW0=5, D0=32'h14 for one cycle → LE=1, RW=5, PW=32'h14 exactly one cycle later; the register file's register 5 reads 32'h14 after the following edge; Busy[5] is high for 2 cycles.
3. **Contention:** V0 and V1 held high with RW0=1..4 and RW1=11..14 → grant order is P0(1), P1(11), P0(2), P1(12), …; LE is continuous; the register file holds all 8 values.
4. **Backpressure:** hold port 0 busy with continuous traffic; push 2 entries to port 1 → R1=0 at count=DEPTH. A third V1 stalls with no loss, and R1 returns to 1 the cycle after port 1 is granted.
5. **r0 discard:** V1=1, RW1=0, D1=32'hFFFFFFFF → popped with LE=0; the register file's register 0 is unchanged; Busy[0] stays 0; Idle returns to 1.
6. **Pointer wrap:** 5 sequential pushes on port 0 only (DEPTH=2) to registers 20..24 → writes appear in order 20..24 with correct data; no duplicates or drops.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// Writeback bus between the two requesters (ALU, load) and the register-file write arbiter.
interface rf_write_arbiter_if #(
  parameter int DW = 32
);
  logic          V0, V1;
  logic          R0, R1;
  logic [4:0]    RW0, RW1;
  logic [DW-1:0] D0, D1;
  logic          LE;
  logic [4:0]    RW;
  logic [DW-1:0] PW;
  logic [31:0]   Busy;
  logic          Idle;

  modport master (
    output V0, V1, RW0, RW1, D0, D1,
    input  R0, R1, LE, RW, PW, Busy, Idle
  );

  modport slave (
    input  V0, V1, RW0, RW1, D0, D1,
    output R0, R1, LE, RW, PW, Busy, Idle
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-port writeback arbiter: per-port FIFOs, round-robin drain, one registered
// register-file write per cycle, and a busy scoreboard of in-flight destinations.
module rf_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int DW    = 32
) (
  input  logic               Clk,
  input  logic               Rst,
  rf_write_arbiter_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [4:0]    fifo_rw [2][DEPTH];
  logic [DW-1:0] fifo_d  [2][DEPTH];
  logic [AW-1:0] wptr [2];
  logic [AW-1:0] rptr [2];
  logic [CW-1:0] cnt  [2];
  logic          last;

  logic [4:0]    rw_in [2];
  logic [DW-1:0] d_in  [2];
  logic [1:0]    v_in, rdy, nempty, push, pop;

  logic          vld_p0, gnt_p0;
  logic [4:0]    head_rw_p0;
  logic [DW-1:0] head_d_p0;

  logic          vld_p1;
  logic [4:0]    rw_p1;
  logic [DW-1:0] pw_p1;

  logic [31:0]   busy;
  logic [AW-1:0] offs;

  assign v_in     = {bus.V1, bus.V0};
  assign rw_in[0] = bus.RW0;
  assign rw_in[1] = bus.RW1;
  assign d_in[0]  = bus.D0;
  assign d_in[1]  = bus.D1;

  // Stage p0: ready from count only, round-robin grant on FIFO heads
  always_comb begin
    rdy    = '0;
    nempty = '0;
    push   = '0;
    pop    = '0;
    for (int p = 0; p < 2; p++) begin
      rdy[p]    = (cnt[p] < FULL);
      nempty[p] = (cnt[p] != '0);
      push[p]   = v_in[p] & rdy[p];
    end
    vld_p0 = |nempty;
    gnt_p0 = (&nempty) ? ~last : nempty[1];
    if (vld_p0) pop[gnt_p0] = 1'b1;
    head_rw_p0 = fifo_rw[gnt_p0][rptr[gnt_p0]];
    head_d_p0  = fifo_d[gnt_p0][rptr[gnt_p0]];
  end

  always_ff @(posedge Clk) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) begin
        fifo_rw[p][wptr[p]] <= rw_in[p];
        fifo_d[p][wptr[p]]  <= d_in[p];
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int p = 0; p < 2; p++) begin
        wptr[p] <= '0;
        rptr[p] <= '0;
        cnt[p]  <= '0;
      end
      last   <= 1'b1;
      vld_p1 <= 1'b0;
      rw_p1  <= '0;
      pw_p1  <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push[p]) wptr[p] <= wptr[p] + PTR_ONE;
        if (pop[p])  rptr[p] <= rptr[p] + PTR_ONE;
        case ({push[p], pop[p]})
          2'b10:   cnt[p] <= cnt[p] + CNT_ONE;
          2'b01:   cnt[p] <= cnt[p] - CNT_ONE;
          default: cnt[p] <= cnt[p];
        endcase
      end
      if (vld_p0) last <= gnt_p0;
      // Stage p1: register-file write port; %g0 entries pop without a write
      vld_p1 <= vld_p0 && (head_rw_p0 != 5'd0);
      if (vld_p0 && (head_rw_p0 != 5'd0)) begin
        rw_p1 <= head_rw_p0;
        pw_p1 <= head_d_p0;
      end
    end
  end

  // An entry is live when its distance from the read pointer is below the count
  always_comb begin
    busy = '0;
    offs = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        offs = AW'(i) - rptr[p];
        if ({1'b0, offs} < cnt[p]) busy[fifo_rw[p][i]] = 1'b1;
      end
    end
    if (vld_p1) busy[rw_p1] = 1'b1;
    busy[0] = 1'b0;
  end

  assign bus.R0   = rdy[0];
  assign bus.R1   = rdy[1];
  assign bus.LE   = vld_p1;
  assign bus.RW   = rw_p1;
  assign bus.PW   = pw_p1;
  assign bus.Busy = busy;
  assign bus.Idle = (cnt[0] == '0) && (cnt[1] == '0) && !vld_p1;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomised and directed bench for rf_write_arbiter against a queue-based reference model.
module tb_rf_write_arbiter;
  localparam int DEPTH = 2;
  localparam int DW    = 32;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  rf_write_arbiter_if #(.DW(DW)) bus ();
  rf_write_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  always #5 Clk = ~Clk;

  int checks = 0;
  int fails  = 0;

  // Register file attached to the write port; %g0 is hard-wired
  logic [31:0] rf [32] = '{default: '0};
  logic [36:0] wr_log [$];
  always @(posedge Clk) begin
    if (bus.LE) begin
      if (bus.RW != 5'd0) rf[bus.RW] <= bus.PW;
      wr_log.push_back({bus.RW, bus.PW});
    end
  end

  // Reference model: FIFOs as queues of {reg, data}
  logic [36:0] mq0 [$];
  logic [36:0] mq1 [$];
  logic        m_le, m_last;
  logic [4:0]  m_rw;
  logic [31:0] m_pw;
  logic [31:0] m_rf [32] = '{default: '0};

  function automatic void model_reset();
    mq0.delete();
    mq1.delete();
    m_le = 1'b0; m_rw = '0; m_pw = '0; m_last = 1'b1;
  endfunction

  function automatic void model_edge(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                     input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    bit r0, r1;
    int g;
    logic [36:0] e;
    r0 = (mq0.size() < DEPTH);
    r1 = (mq1.size() < DEPTH);
    if (m_le && m_rw != 5'd0) m_rf[m_rw] = m_pw;
    if (mq0.size() > 0 && mq1.size() > 0) g = m_last ? 0 : 1;
    else if (mq0.size() > 0) g = 0;
    else if (mq1.size() > 0) g = 1;
    else g = -1;
    m_le = 1'b0;
    if (g >= 0) begin
      if (g == 0) e = mq0.pop_front(); else e = mq1.pop_front();
      m_last = (g == 1);
      if (e[36:32] != 5'd0) begin
        m_le = 1'b1; m_rw = e[36:32]; m_pw = e[31:0];
      end
    end
    if (v0 && r0) mq0.push_back({a0, d0});
    if (v1 && r1) mq1.push_back({a1, d1});
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    foreach (mq0[i]) b[mq0[i][36:32]] = 1'b1;
    foreach (mq1[i]) b[mq1[i][36:32]] = 1'b1;
    if (m_le) b[m_rw] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  // {R0, R1, Idle, LE, RW, PW, Busy}
  function automatic logic [72:0] exp_vec();
    logic idle;
    idle = (mq0.size() == 0) && (mq1.size() == 0) && !m_le;
    return {mq0.size() < DEPTH, mq1.size() < DEPTH, idle, m_le, m_rw, m_pw, model_busy()};
  endfunction

  function automatic logic [72:0] dut_vec();
    return {bus.R0, bus.R1, bus.Idle, bus.LE, bus.RW, bus.PW, bus.Busy};
  endfunction

  localparam logic [72:0] RESET_VEC = {1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0};

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    bus.V0 = v0; bus.RW0 = a0; bus.D0 = d0;
    bus.V1 = v1; bus.RW1 = a1; bus.D1 = d1;
  endtask

  task automatic tick();
    @(posedge Clk);
    if (Rst) model_reset();
    else model_edge(bus.V0, bus.RW0, bus.D0, bus.V1, bus.RW1, bus.D1);
    @(negedge Clk);
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, 0, 0);
    Rst = 1'b1;
    #1;
    model_reset();
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0);
    #1 Rst = 1'b1;
    #2;
    if (dut_vec() !== RESET_VEC) begin
      fails++; $display("FAIL reset_initial: got %h want %h", dut_vec(), RESET_VEC);
    end
    checks++;
    model_reset();
    @(negedge Clk);
    Rst = 1'b0;
    drive(1, 5'd3, $urandom, 1, 5'd7, $urandom);
    tick();
    drive(1, 5'd9, $urandom, 1, 5'd8, $urandom);
    tick();
    if (dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL reset_queued: got %h want %h", dut_vec(), exp_vec());
    end
    checks++;
    #2 Rst = 1'b1;
    #1;
    if (dut_vec() !== RESET_VEC) begin
      fails++; $display("FAIL reset_midop: got %h want %h", dut_vec(), RESET_VEC);
    end
    checks++;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge Clk);
    Rst = 1'b0;
    tick();
    if (dut_vec() !== exp_vec() || dut_vec() !== RESET_VEC) begin
      fails++; $display("FAIL reset_after: got %h want %h", dut_vec(), RESET_VEC);
    end
    checks++;
  endtask

  task automatic test_single_write();
    apply_reset();
    drive(1, 5'd5, 32'h14, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    if (bus.LE !== 1'b0 || bus.Busy !== 32'h20 || bus.Idle !== 1'b0) begin
      fails++; $display("FAIL single_queued: got LE=%b Busy=%h Idle=%b want LE=0 Busy=00000020 Idle=0", bus.LE, bus.Busy, bus.Idle);
    end
    checks++;
    tick();
    if (bus.LE !== 1'b1 || bus.RW !== 5'd5 || bus.PW !== 32'h14 || bus.Busy !== 32'h20) begin
      fails++; $display("FAIL single_write: got LE=%b RW=%0d PW=%h Busy=%h want 1 5 00000014 00000020", bus.LE, bus.RW, bus.PW, bus.Busy);
    end
    checks++;
    tick();
    if (rf[5] !== 32'h14 || bus.LE !== 1'b0 || bus.Busy !== 32'h0 || bus.Idle !== 1'b1) begin
      fails++; $display("FAIL single_done: got rf5=%h LE=%b Busy=%h Idle=%b want 00000014 0 0 1", rf[5], bus.LE, bus.Busy, bus.Idle);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL single_model: got %h want %h", dut_vec(), exp_vec());
    end
    checks++;
  endtask

  task automatic test_contention();
    logic [31:0] cd0 [4];
    logic [31:0] cd1 [4];
    int i0 = 0, i1 = 0, base, first_le = -1, last_le = -1, n_le = 0;
    bit a0, a1;
    logic [36:0] want;
    apply_reset();
    for (int k = 0; k < 4; k++) begin cd0[k] = $urandom; cd1[k] = $urandom; end
    base = wr_log.size();
    for (int c = 0; c < 14; c++) begin
      drive(i0 < 4, 5'(1 + i0), (i0 < 4) ? cd0[i0 % 4] : 32'd0,
            i1 < 4, 5'(11 + i1), (i1 < 4) ? cd1[i1 % 4] : 32'd0);
      a0 = bus.V0 && (mq0.size() < DEPTH);
      a1 = bus.V1 && (mq1.size() < DEPTH);
      tick();
      if (a0) i0++;
      if (a1) i1++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL contention_cyc%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      checks++;
      if (bus.LE) begin
        if (first_le < 0) first_le = c;
        last_le = c; n_le++;
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    if (n_le != 8 || last_le - first_le != 7) begin
      fails++; $display("FAIL contention_le_run: got %0d writes over span %0d want 8 over 7", n_le, last_le - first_le);
    end
    checks++;
    for (int k = 0; k < 8; k++) begin
      want = (k % 2 == 0) ? {5'(1 + k / 2), cd0[k / 2]} : {5'(11 + k / 2), cd1[k / 2]};
      if (wr_log.size() <= base + k || wr_log[base + k] !== want) begin
        fails++; $display("FAIL contention_order%0d: got %h want %h", k,
                          (wr_log.size() > base + k) ? wr_log[base + k] : 37'h0, want);
      end
      checks++;
    end
    for (int k = 0; k < 4; k++) begin
      if (rf[1 + k] !== cd0[k] || rf[11 + k] !== cd1[k]) begin
        fails++; $display("FAIL contention_rf%0d: got %h/%h want %h/%h", k, rf[1 + k], rf[11 + k], cd0[k], cd1[k]);
      end
      checks++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] bd [3];
    int i1 = 0, base, n1 = 0;
    bit a1, saw_low = 0;
    apply_reset();
    for (int k = 0; k < 3; k++) bd[k] = $urandom;
    base = wr_log.size();
    for (int c = 0; c < 26; c++) begin
      drive(c < 20, 5'($urandom_range(1, 9)), $urandom,
            i1 < 3, 5'(25 + i1), (i1 < 3) ? bd[i1 % 3] : 32'd0);
      a1 = bus.V1 && (mq1.size() < DEPTH);
      if (bus.V1 && bus.R1 === 1'b0) saw_low = 1;
      tick();
      if (a1) i1++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL backpressure_cyc%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      checks++;
    end
    drive(0, 0, 0, 0, 0, 0);
    if (!saw_low || i1 != 3) begin
      fails++; $display("FAIL backpressure_stall: got r1_low=%0d accepted=%0d want 1 3", saw_low, i1);
    end
    checks++;
    for (int k = base; k < wr_log.size(); k++) begin
      if (wr_log[k][36:32] >= 5'd25) begin
        if (wr_log[k] !== {5'(25 + n1 % 3), bd[n1 % 3]}) begin
          fails++; $display("FAIL backpressure_p1_%0d: got %h want %h", n1, wr_log[k], {5'(25 + n1 % 3), bd[n1 % 3]});
        end
        checks++;
        n1++;
      end
    end
    if (n1 != 3) begin
      fails++; $display("FAIL backpressure_count: got %0d want 3", n1);
    end
    checks++;
  endtask

  task automatic test_r0_discard();
    int base;
    apply_reset();
    base = wr_log.size();
    drive(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    if (bus.Busy !== 32'h0 || bus.Idle !== 1'b0) begin
      fails++; $display("FAIL r0_queued: got Busy=%h Idle=%b want 00000000 0", bus.Busy, bus.Idle);
    end
    checks++;
    tick();
    if (bus.LE !== 1'b0 || bus.Busy !== 32'h0 || bus.Idle !== 1'b1) begin
      fails++; $display("FAIL r0_popped: got LE=%b Busy=%h Idle=%b want 0 00000000 1", bus.LE, bus.Busy, bus.Idle);
    end
    checks++;
    tick();
    if (rf[0] !== 32'h0 || wr_log.size() != base) begin
      fails++; $display("FAIL r0_nowrite: got rf0=%h writes=%0d want 0 0", rf[0], wr_log.size() - base);
    end
    checks++;
  endtask

  task automatic test_wrap();
    logic [31:0] wd [5];
    int i0 = 0, base;
    bit a0;
    apply_reset();
    for (int k = 0; k < 5; k++) wd[k] = $urandom;
    base = wr_log.size();
    for (int c = 0; c < 12; c++) begin
      drive(i0 < 5, 5'(20 + i0), (i0 < 5) ? wd[i0 % 5] : 32'd0, 0, 0, 0);
      a0 = bus.V0 && (mq0.size() < DEPTH);
      tick();
      if (a0) i0++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL wrap_cyc%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      checks++;
    end
    drive(0, 0, 0, 0, 0, 0);
    if (wr_log.size() - base != 5) begin
      fails++; $display("FAIL wrap_count: got %0d want 5", wr_log.size() - base);
    end
    checks++;
    for (int k = 0; k < 5 && base + k < wr_log.size(); k++) begin
      if (wr_log[base + k] !== {5'(20 + k), wd[k]}) begin
        fails++; $display("FAIL wrap_order%0d: got %h want %h", k, wr_log[base + k], {5'(20 + k), wd[k]});
      end
      checks++;
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
      tick();
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL random_cyc%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      checks++;
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 8; c++) tick();
    if (bus.Idle !== 1'b1) begin
      fails++; $display("FAIL random_drain: got Idle=%b want 1", bus.Idle);
    end
    checks++;
    for (int r = 0; r < 32; r++) begin
      if (rf[r] !== m_rf[r]) begin
        fails++; $display("FAIL random_rf%0d: got %h want %h", r, rf[r], m_rf[r]);
      end
      checks++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_single_write();
    test_contention();
    test_backpressure();
    test_r0_discard();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
